// File: rtl/sub_serial.sv
// Bit-serial N-bit subtractor, LSB first, one bit per clock.
// D = (A - B - Bi) mod 2^N with registered borrow-out and start/done handshake.
module sub_serial #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Bi,
  output logic [N-1:0] D,
  output logic         Bout,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   a_sr_q, a_sr_d;
  logic [N-1:0]   b_sr_q, b_sr_d;
  logic [N-1:0]   r_sr_q, r_sr_d;
  logic [N-1:0]   d_q, d_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           br_q, br_d;
  logic           bout_q, bout_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic a0, b0, dbit, br_nxt;

  // 1-bit full-subtractor cell
  assign a0     = a_sr_q[0];
  assign b0     = b_sr_q[0];
  assign dbit   = a0 ^ b0 ^ br_q;
  assign br_nxt = (~a0 & b0) | (~(a0 ^ b0) & br_q);

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    r_sr_d  = r_sr_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bout_d  = bout_q;
    busy_d  = busy_q;
    done_d  = done_q;
    unique case (state_q)
      IDLE, DONE: begin
        done_d  = 1'b0;
        state_d = IDLE;
        if (start) begin
          a_sr_d  = A;
          b_sr_d  = B;
          br_d    = Bi;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        r_sr_d = {dbit, r_sr_q[N-1:1]};
        br_d   = br_nxt;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          d_d     = {dbit, r_sr_q[N-1:1]};
          bout_d  = br_nxt;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      r_sr_q  <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      r_sr_q  <= r_sr_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign D    = d_q;
  assign Bout = bout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_sub_serial.sv
// Testbench for sub_serial: N=8 and N=4 instances against
// an arithmetic reference model, plus directed literal checks.
module tb_sub_serial;

  logic clk, rst;
  logic st8, bi8, st4, bi4;
  logic [7:0] a8, b8, D8;
  logic [3:0] a4, b4, D4;
  logic bo8, busy8, done8;
  logic bo4, busy4, done4;

  int errors = 0;
  int checks = 0;

  sub_serial #(.N(8)) u8 (
    .clk(clk), .rst(rst), .start(st8),
    .A(a8), .B(b8), .Bi(bi8),
    .D(D8), .Bout(bo8),
    .busy(busy8), .done(done8)
  );

  sub_serial #(.N(4)) u4 (
    .clk(clk), .rst(rst), .start(st4),
    .A(a4), .B(b4), .Bi(bi4),
    .D(D4), .Bout(bo4),
    .busy(busy4), .done(done4)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  // Model: an accepted op finishes n cycles later with the
  // plain integer result A-B-Bi; negative means borrow.
  int m_left[2];
  int m_res[2];
  int m_D[2];
  bit m_bo[2], m_busy[2], m_done[2];

  task automatic mstep(input int i, input int n, input bit st,
                       input int a, input int b, input bit bi);
    if (m_left[i] > 0) begin
      m_left[i]--;
      if (m_left[i] == 0) begin
        m_D[i]    = m_res[i] & ((1 << n) - 1);
        m_bo[i]   = (m_res[i] < 0);
        m_busy[i] = 0;
        m_done[i] = 1;
      end
    end else begin
      m_done[i] = 0;
      if (st) begin
        m_res[i]  = a - b - int'(bi);
        m_left[i] = n;
        m_busy[i] = 1;
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_left[i] = 0; m_res[i] = 0; m_D[i] = 0;
        m_bo[i] = 0; m_busy[i] = 0; m_done[i] = 0;
      end
    end else begin
      mstep(0, 8, st8, int'(a8), int'(b8), bi8);
      mstep(1, 4, st4, int'(a4), int'(b4), bi4);
    end
  end

  always @(negedge clk) begin
    chk("d8_D", int'(D8), m_D[0]);
    chk("d8_Bout", int'(bo8), int'(m_bo[0]));
    chk("d8_busy", int'(busy8), int'(m_busy[0]));
    chk("d8_done", int'(done8), int'(m_done[0]));
    chk("d4_D", int'(D4), m_D[1]);
    chk("d4_Bout", int'(bo4), int'(m_bo[1]));
    chk("d4_busy", int'(busy4), int'(m_busy[1]));
    chk("d4_done", int'(done4), int'(m_done[1]));
  end

  // One N=8 op with noise on inputs during SHIFT.
  task automatic op8(input int a, input int b, input bit bi,
                     output int lat, output int bcnt);
    st8 = 1; a8 = 8'(a); b8 = 8'(b); bi8 = bi;
    @(negedge clk);
    st8 = 0; lat = 0; bcnt = 0;
    while (!done8 && lat < 40) begin
      if (busy8) bcnt++;
      st8 = 1'($urandom); a8 = 8'($urandom);
      b8 = 8'($urandom); bi8 = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    st8 = 0;
    if (lat >= 40) chk("op8_timeout", lat, 8);
  endtask

  int lat, bc, t, ra, rb;
  bit rbi;

  initial begin
    rst = 1; st8 = 0; a8 = 0; b8 = 0; bi8 = 0;
    st4 = 0; a4 = 0; b4 = 0; bi4 = 0;
    #12;
    chk("rst_D", int'(D8), 0);
    chk("rst_Bout", int'(bo8), 0);
    chk("rst_busy", int'(busy8), 0);
    chk("rst_done", int'(done8), 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);

    op8(5, 3, 0, lat, bc);
    chk("lat_5m3", lat, 8);
    chk("busy_cyc", bc, 8);
    chk("D_5m3", int'(D8), 8'h02);
    chk("Bo_5m3", int'(bo8), 0);
    @(negedge clk);
    chk("done_1cyc", int'(done8), 0);

    op8(3, 5, 0, lat, bc);
    chk("D_3m5", int'(D8), 8'hFE);
    chk("Bo_3m5", int'(bo8), 1);
    op8(0, 0, 1, lat, bc);
    chk("D_0m0m1", int'(D8), 8'hFF);
    chk("Bo_0m0m1", int'(bo8), 1);
    op8(255, 255, 0, lat, bc);
    chk("D_ffmff", int'(D8), 0);
    chk("Bo_ffmff", int'(bo8), 0);

    // back-to-back with start held high
    st8 = 1; a8 = 10; b8 = 4; bi8 = 0;
    t = 0;
    do begin
      @(negedge clk); t++;
      if (!done8) begin a8 = 8'($urandom); b8 = 8'($urandom); end
    end while (!done8 && t < 40);
    chk("b2b_D1", int'(D8), 6);
    chk("b2b_Bo1", int'(bo8), 0);
    a8 = 4; b8 = 10; bi8 = 0;
    t = 0;
    do begin
      @(negedge clk); t++;
      if (!done8) begin a8 = 8'($urandom); b8 = 8'($urandom); end
    end while (!done8 && t < 40);
    st8 = 0;
    chk("b2b_gap", t, 9);
    chk("b2b_D2", int'(D8), 8'hFA);
    chk("b2b_Bo2", int'(bo8), 1);
    @(negedge clk);
    @(negedge clk);

    // async reset mid-operation
    st8 = 1; a8 = 8'($urandom); b8 = 8'($urandom); bi8 = 0;
    @(negedge clk);
    st8 = 0;
    repeat (3) @(negedge clk);
    #2 rst = 1;
    #1;
    chk("arst_D", int'(D8), 0);
    chk("arst_Bout", int'(bo8), 0);
    chk("arst_busy", int'(busy8), 0);
    chk("arst_done", int'(done8), 0);
    @(negedge clk);
    rst = 0;
    repeat (12) begin
      @(negedge clk);
      chk("no_done_after_rst", int'(done8), 0);
    end
    op8(100, 37, 1, lat, bc);
    chk("post_rst_lat", lat, 8);
    chk("post_rst_D", int'(D8), 62);

    // randomized N=8 ops
    for (int k = 0; k < 40; k++) begin
      ra = int'($urandom_range(0, 255));
      rb = int'($urandom_range(0, 255));
      rbi = 1'($urandom);
      op8(ra, rb, rbi, lat, bc);
      chk("rand_lat", lat, 8);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    // exhaustive N=4
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++) begin
          st4 = 1; a4 = 4'(a); b4 = 4'(b); bi4 = 1'(c);
          @(negedge clk);
          st4 = 0; t = 0;
          while (!done4 && t < 20) begin
            @(negedge clk); t++;
          end
          chk("ex4_D", int'(D4), (a - b - c) & 15);
          chk("ex4_Bout", int'(bo4), int'(a < b + c));
        end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sub_serial.md
Name: sub_serial

Overview:
- Bit-serial N-bit subtractor. Computes D = A - B - Bi, LSB first, one bit per clock.
- Uses a 1-bit full-subtractor cell and a borrow flip-flop. It is the subtract-direction counterpart of the team's 1-bit full adder.
- Sits beside the adder datapath as a low-area arithmetic unit with a start/done handshake.

Parameters:
- N, 8, operand and result width in bits (N >= 2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled on clk rising edge.
- A  input  N  minuend; captured when start is accepted.
- B  input  N  subtrahend; captured when start is accepted.
- Bi  input  1  borrow-in; captured when start is accepted.
- D  output  N  difference, registered.
- Bout  output  1  borrow-out, registered; 1 when A < B + Bi (unsigned).
- busy  output  1  high while subtraction is in progress.
- done  output  1  one-cycle pulse; D and Bout are valid.

Behaviour:
- Reset (async, any time): state=IDLE, D=0, Bout=0, busy=0, done=0, internal shift registers, borrow and counter = 0.
- An in-flight operation is aborted by reset and produces no done pulse.
- States: IDLE, SHIFT, DONE.
- IDLE or DONE, start=1 at edge k:
  - load a_sr<=A, b_sr<=B, br<=Bi, cnt<=0.
  - state<=SHIFT, busy<=1, done<=0.
- SHIFT, each edge:
  - a0=a_sr[0], b0=b_sr[0].
  - d=a0^b0^br.
  - br<=(~a0&b0)|(~(a0^b0)&br).
  - result shift register takes d into its MSB and shifts right.
  - a_sr and b_sr shift right.
  - cnt<=cnt+1.
- The last SHIFT edge (cnt==N-1) also does the following:
  - D<=final result (including this bit) and Bout<=final borrow.
  - busy<=0, done<=1, state<=DONE.
- Latency: start accepted at edge k; done high in the cycle after edge k+N. busy is high between edges k and k+N.
- DONE lasts exactly one cycle, then state<=IDLE and done<=0, unless start=1 in that cycle. In that case the new operation is accepted (back-to-back; done falls, busy rises).
- D and Bout hold their values from the done edge until the next done edge or reset. They do not change during a subsequent SHIFT phase.
- start while in SHIFT is ignored. Operands are not re-sampled; A/B/Bi may change freely after acceptance.
- Arithmetic is unsigned modulo 2^N: D = (A - B - Bi) mod 2^N.
- Bout is the 2^N borrow (equivalently, NOT of the carry in A + ~B + ~Bi).
- cnt is ceil(log2(N)) bits wide. There is no wrap-around hazard because SHIFT exits at N-1.

Test Plan:
- N=8, A=5, B=3, Bi=0, one-cycle start -> done pulses once, exactly 8 cycles after the accepting edge; D=8'h02, Bout=0; busy high for 8 cycles.
- N=8, A=3, B=5, Bi=0 -> D=8'hFE, Bout=1.
- N=8, A=0, B=0, Bi=1 -> D=8'hFF, Bout=1.
- N=8, A=8'hFF, B=8'hFF, Bi=0 -> D=0, Bout=0.
- Hold start=1 continuously with A=10, B=4, then A=4, B=10 (new operands applied in the done cycle):
  - results 6/Bout=0, then 8'hFA/Bout=1.
  - done pulses separated by exactly N+1 cycles; no idle gap.
  - operand changes and start pulses during SHIFT have no effect.
- Reset and exhaustive check:
  - assert rst 3 cycles into an operation -> D, Bout, busy, done all 0 immediately (asynchronously); no done follows; the next start works normally.
  - N=4, sweep all A, B, Bi (512 cases) against reference model A-B-Bi -> all match.
